// File: rtl/ballgame_pkg.sv
// Shared encodings for the paddle game: scan codes, mode states, player/direction.
package ballgame_pkg;

  localparam logic [7:0] KEY_P1_L  = 8'h15;
  localparam logic [7:0] KEY_P1_R  = 8'h1D;
  localparam logic [7:0] KEY_P2_L  = 8'h44;
  localparam logic [7:0] KEY_P2_R  = 8'h4D;
  localparam logic [7:0] KEY_START = 8'h5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } mode_e;

  localparam logic PLAYER_1  = 1'b0;
  localparam logic PLAYER_2  = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/cmd_fifo2.sv
// Two-entry, one-bit request FIFO. Head is always mem_q[0]; a pop shifts down.
// Push and pop in the same cycle on a full FIFO both take effect.
module cmd_fifo2 #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  input  logic flush,
  output logic dout,
  output logic empty,
  output logic full,
  output logic drop
);

  logic [1:0] count_q, count_d;
  logic [1:0] mem_q, mem_d;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'(DEPTH));
  assign dout  = mem_q[0];
  assign drop  = push && full && !pop;

  // Next occupancy/contents: pop first so a push can reuse the freed slot.
  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && !empty) begin
        mem_d   = {1'b0, mem_q[1]};
        count_d = count_q - 2'd1;
      end
      if (push && (count_d != 2'(DEPTH))) begin
        mem_d[count_d[0]] = din;
        count_d           = count_d + 2'd1;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      mem_q   <= 2'b00;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/paddle_cmd_scheduler.sv
// Turns keyboard make codes into paddle move commands on a single engine port.
//
//   state | meaning
//   IDLE  | after reset, waiting for the first start key
//   RUN   | game running; move keys queued and dispatched
//   PAUSE | game paused; queues empty, in-flight command may still be acked
module paddle_cmd_scheduler
  import ballgame_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kb_code,
  input  logic       kb_ready,
  output logic       mv_valid,
  output logic       mv_player,
  output logic       mv_dir,
  input  logic       mv_ack,
  output logic       game_run,
  output logic       start_pulse,
  output logic       drop_pulse
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  mode_e         state_q, state_d;
  logic          game_run_q, game_run_d;
  logic          start_pulse_q, start_pulse_d;
  logic          drop_pulse_q, drop_pulse_d;
  logic          mv_valid_q, mv_valid_d;
  logic          mv_player_q, mv_player_d;
  logic          mv_dir_q, mv_dir_d;
  logic          rr_q, rr_d;
  logic [GW-1:0] gap_q, gap_d;

  logic in_run, start_key, flush;
  logic push1, push2, din1, din2;
  logic pop1, pop2, head1, head2;
  logic empty1, empty2, full1, full2, drop1, drop2;
  logic grant, sel;

  assign in_run    = (state_q == RUN);
  assign start_key = kb_ready && (kb_code == KEY_START);
  assign flush     = in_run && start_key;

  assign push1 = in_run && kb_ready && ((kb_code == KEY_P1_L) || (kb_code == KEY_P1_R));
  assign push2 = in_run && kb_ready && ((kb_code == KEY_P2_L) || (kb_code == KEY_P2_R));
  assign din1  = (kb_code == KEY_P1_R) ? DIR_RIGHT : DIR_LEFT;
  assign din2  = (kb_code == KEY_P2_R) ? DIR_RIGHT : DIR_LEFT;

  cmd_fifo2 #(.DEPTH(FIFO_DEPTH)) u_fifo_p1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .din   (din1),
    .pop   (pop1),
    .flush (flush),
    .dout  (head1),
    .empty (empty1),
    .full  (full1),
    .drop  (drop1)
  );

  cmd_fifo2 #(.DEPTH(FIFO_DEPTH)) u_fifo_p2 (
    .clk   (clk),
    .reset (reset),
    .push  (push2),
    .din   (din2),
    .pop   (pop2),
    .flush (flush),
    .dout  (head2),
    .empty (empty2),
    .full  (full2),
    .drop  (drop2)
  );

  // Mode sequencing on the start key; game_run tracks the next state so it is a flop.
  always_comb begin
    state_d       = state_q;
    start_pulse_d = 1'b0;
    if (start_key) begin
      unique case (state_q)
        IDLE: begin
          state_d       = RUN;
          start_pulse_d = 1'b1;
        end
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    game_run_d = (state_d == RUN);
  end

  // Arbitration, output handshake and gap down-counter. No grant in the cycle
  // that leaves RUN so flushed entries are never dispatched.
  always_comb begin
    grant        = !mv_valid_q && (gap_q == '0) && in_run && !start_key && !(empty1 && empty2);
    sel          = (!empty1 && !empty2) ? rr_q : (empty1 ? PLAYER_2 : PLAYER_1);
    pop1         = grant && (sel == PLAYER_1);
    pop2         = grant && (sel == PLAYER_2);
    mv_valid_d   = mv_valid_q;
    mv_player_d  = mv_player_q;
    mv_dir_d     = mv_dir_q;
    rr_d         = rr_q;
    gap_d        = gap_q;
    drop_pulse_d = drop1 || drop2;
    if (grant) begin
      mv_valid_d  = 1'b1;
      mv_player_d = sel;
      mv_dir_d    = (sel == PLAYER_2) ? head2 : head1;
      rr_d        = ~sel;
    end else if (mv_valid_q && mv_ack) begin
      mv_valid_d = 1'b0;
      gap_d      = GW'(GAP_CYCLES);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      game_run_q    <= 1'b0;
      start_pulse_q <= 1'b0;
      drop_pulse_q  <= 1'b0;
      mv_valid_q    <= 1'b0;
      mv_player_q   <= PLAYER_1;
      mv_dir_q      <= DIR_LEFT;
      rr_q          <= PLAYER_1;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      game_run_q    <= game_run_d;
      start_pulse_q <= start_pulse_d;
      drop_pulse_q  <= drop_pulse_d;
      mv_valid_q    <= mv_valid_d;
      mv_player_q   <= mv_player_d;
      mv_dir_q      <= mv_dir_d;
      rr_q          <= rr_d;
      gap_q         <= gap_d;
    end
  end

  assign mv_valid    = mv_valid_q;
  assign mv_player   = mv_player_q;
  assign mv_dir      = mv_dir_q;
  assign game_run    = game_run_q;
  assign start_pulse = start_pulse_q;
  assign drop_pulse  = drop_pulse_q;

endmodule

// File: tb/tb_paddle_cmd_scheduler.sv
// Bench for paddle_cmd_scheduler: directed openers, then randomized traffic
// against a queue-based reference model, with asynchronous resets mid-run.
module tb_paddle_cmd_scheduler;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] kb_code;
  logic       kb_ready;
  logic       mv_ack;
  logic       mv_valid, mv_player, mv_dir, game_run, start_pulse, drop_pulse;

  paddle_cmd_scheduler #(.GAP_CYCLES(GAP), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .kb_code     (kb_code),
    .kb_ready    (kb_ready),
    .mv_valid    (mv_valid),
    .mv_player   (mv_player),
    .mv_dir      (mv_dir),
    .mv_ack      (mv_ack),
    .game_run    (game_run),
    .start_pulse (start_pulse),
    .drop_pulse  (drop_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=pause, per-player request queues.
  int m_mode;
  bit q1[$];
  bit q2[$];
  bit m_vld, m_pl, m_dir, m_rr, m_sp, m_drop;
  int m_gap;

  task automatic model_reset();
    m_mode = 0;
    q1.delete();
    q2.delete();
    m_vld = 0; m_pl = 0; m_dir = 0; m_rr = 0; m_sp = 0; m_drop = 0;
    m_gap = 0;
  endtask

  // One clock of the model, from the inputs currently on the bus.
  task automatic model_step();
    bit start, run, grant, p, d;
    start = kb_ready && (kb_code == 8'h5A);
    run   = (m_mode == 1);
    m_sp   = 0;
    m_drop = 0;
    grant = !m_vld && (m_gap == 0) && run && !start && ((q1.size() + q2.size()) > 0);
    if (grant) begin
      if (q1.size() > 0 && q2.size() > 0) p = m_rr;
      else p = (q1.size() > 0) ? 1'b0 : 1'b1;
      if (p) d = q2.pop_front(); else d = q1.pop_front();
      m_vld = 1; m_pl = p; m_dir = d; m_rr = !p;
    end else if (m_vld && mv_ack) begin
      m_vld = 0;
      m_gap = GAP;
    end else if (m_gap > 0) begin
      m_gap--;
    end
    if (run && kb_ready) begin
      if (kb_code == 8'h15 || kb_code == 8'h1D) begin
        if (q1.size() < 2) q1.push_back(kb_code == 8'h1D); else m_drop = 1;
      end else if (kb_code == 8'h44 || kb_code == 8'h4D) begin
        if (q2.size() < 2) q2.push_back(kb_code == 8'h4D); else m_drop = 1;
      end
    end
    if (start) begin
      case (m_mode)
        0: begin m_mode = 1; m_sp = 1; end
        1: begin m_mode = 2; q1.delete(); q2.delete(); end
        default: m_mode = 1;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("mv_valid", mv_valid, m_vld);
    chk("mv_player", mv_player, m_pl);
    chk("mv_dir", mv_dir, m_dir);
    chk("game_run", game_run, m_mode == 1);
    chk("start_pulse", start_pulse, m_sp);
    chk("drop_pulse", drop_pulse, m_drop);
  endtask

  // Drive one cycle of inputs (called just after a rising edge), advance, compare.
  task automatic cycle(input logic [7:0] code, input logic rdy, input logic ack);
    kb_code  = code;
    kb_ready = rdy;
    mv_ack   = ack;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    kb_ready = 0;
    mv_ack   = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mv_valid", mv_valid, 0);
    chk("rst_game_run", game_run, 0);
    chk("rst_player_dir", {mv_player, mv_dir}, 0);
    chk("rst_pulses", {start_pulse, drop_pulse}, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] codes [5];
    int ack_pct;
    codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h44; codes[3] = 8'h4D; codes[4] = 8'h5A;
    reset = 1'b1; kb_code = 8'h00; kb_ready = 1'b0; mv_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    compare_all();

    // Start / pause / resume.
    cycle(8'h5A, 1, 0);
    chk("start_game_run", game_run, 1);
    chk("start_pulse_1st", start_pulse, 1);
    cycle(8'h00, 0, 0);
    chk("start_pulse_gone", start_pulse, 0);
    cycle(8'h5A, 1, 0);
    chk("pause_game_run", game_run, 0);
    cycle(8'h5A, 1, 0);
    chk("resume_no_pulse", start_pulse, 0);

    // Single P1-right with ack tied high: valid exactly at N+2.
    cycle(8'h1D, 1, 1);
    chk("lat_n1", mv_valid, 0);
    cycle(8'h00, 0, 1);
    chk("lat_n2", {mv_valid, mv_player, mv_dir}, 3'b101);
    cycle(8'h00, 0, 1);
    chk("ack_drop", mv_valid, 0);
    repeat (GAP + 2) cycle(8'h00, 0, 1);

    // P1-left and P2-right under back-pressure, then four P2-left to force a drop.
    cycle(8'h15, 1, 0);
    cycle(8'h4D, 1, 0);
    repeat (10) begin
      cycle(8'h00, 0, 0);
      chk("hold_payload", {mv_valid, mv_player, mv_dir}, 3'b100);
    end
    repeat (3) cycle(8'h00, 0, 1);
    repeat (GAP + 1) cycle(8'h00, 0, 0);
    chk("second_is_p2r", {mv_valid, mv_player, mv_dir}, 3'b111);
    repeat (4) cycle(8'h44, 1, 0);
    chk("full_drop", drop_pulse, 1);

    // Pause with a command in flight, then reset while it is still offered.
    cycle(8'h5A, 1, 0);
    cycle(8'h44, 1, 0);
    repeat (5) cycle(8'h00, 0, 0);
    chk("inflight_held", mv_valid, 1);
    async_reset();

    // Randomized traffic in phases of varying engine back-pressure.
    for (int ph = 0; ph < 16; ph++) begin
      case (ph % 4)
        0: ack_pct = 100;
        1: ack_pct = 50;
        2: ack_pct = 10;
        default: ack_pct = 0;
      endcase
      for (int i = 0; i < 250; i++) begin
        logic [7:0] c;
        int r;
        r = $urandom_range(19);
        if (r < 16) c = codes[r / 4];
        else if (r == 16 || (m_mode != 1 && r == 17)) c = codes[4];
        else c = 8'($urandom);
        cycle(c, ($urandom_range(99) < 35), ($urandom_range(99) < ack_pct));
      end
      if (ph % 5 == 4) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
